io_bus_arbiter: RTL

//  Shares one 8-bit, 16-bit-address I/O bus (addr, data, ior_, iow_) between two requesters.

---
 rtl/io_bus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter driving an 8-bit I/O bus with timed ior_/iow_ strobes.
// An optional status-poll phase reads a status port until READY_BIT is set, then transfers at addr+1.
module io_bus_arbiter #(
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned READY_BIT  = 5,
  parameter int unsigned MAX_POLL   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        poll0,
  input  logic        poll1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] addr,
  inout  wire  [7:0]  data,
  output logic        ior_,
  output logic        iow_
);

  localparam int unsigned PW = $clog2(MAX_POLL + 1);
  localparam int unsigned SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STRB, HOLD, DONE} state_t;
  state_t state, state_nx;

  logic          gnt;
  logic          last_gnt;
  logic          lwr;
  logic          data_ph;
  logic [15:0]   laddr;
  logic [7:0]    lwdata;
  logic          status_rdy;
  logic [SW-1:0] strb_cnt;
  logic [PW-1:0] poll_cnt;
  logic          timeout;
  logic          take0, take1, strb_end, poll_out, wr_access, drive;

  // last_gnt=1 means req1 was served last, so req0 wins a tie
  always_comb begin
    take0     = req0 && (!req1 || last_gnt);
    take1     = req1 && !take0;
    strb_end  = (strb_cnt == SW'(STROBE_CYC - 1));
    poll_out  = (poll_cnt == PW'(MAX_POLL - 1));
    wr_access = lwr && data_ph;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req0 || req1) state_nx = SETUP;
      SETUP: state_nx = STRB;
      STRB:  if (strb_end) state_nx = HOLD;
      HOLD: begin
        if (data_ph)         state_nx = DONE;
        else if (status_rdy) state_nx = SETUP;
        else if (poll_out)   state_nx = DONE;
        else                 state_nx = SETUP;
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt        <= 1'b0;
      last_gnt   <= 1'b1;
      lwr        <= 1'b0;
      data_ph    <= 1'b0;
      laddr      <= '0;
      lwdata     <= '0;
      status_rdy <= 1'b0;
      strb_cnt   <= '0;
      poll_cnt   <= '0;
      timeout    <= 1'b0;
      addr       <= '0;
      rdata      <= '0;
    end else begin
      unique case (state)
        IDLE: if (take0 || take1) begin
          gnt      <= take1;
          last_gnt <= take1;
          lwr      <= take1 ? wr1    : wr0;
          data_ph  <= !(take1 ? poll1 : poll0);
          laddr    <= take1 ? addr1  : addr0;
          addr     <= take1 ? addr1  : addr0;
          lwdata   <= take1 ? wdata1 : wdata0;
          poll_cnt <= '0;
          timeout  <= 1'b0;
        end
        SETUP: strb_cnt <= '0;
        STRB: begin
          strb_cnt <= strb_cnt + 1'b1;
          if (strb_end && !wr_access) begin
            if (data_ph) rdata      <= data;
            else         status_rdy <= data[READY_BIT];
          end
        end
        HOLD: if (!data_ph) begin
          if (status_rdy) begin
            data_ph  <= 1'b1;
            poll_cnt <= '0;
            addr     <= laddr + 16'd1;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            if (poll_out) timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy  = (state != IDLE);
    ior_  = !((state == STRB) && !wr_access);
    iow_  = !((state == STRB) && wr_access);
    ack0  = (state == DONE) && !gnt;
    ack1  = (state == DONE) && gnt;
    err   = (state == DONE) && timeout;
    drive = wr_access && ((state == SETUP) || (state == STRB) || (state == HOLD));
  end

  assign data = drive ? lwdata : 8'hzz;

endmodule
